// File: rtl/caches_types_pkg.sv
// Shared types for the cache/RAM side of the dual-core system.
// Holds the memory arbiter's state encoding, grant record and timeout defaults.
package caches_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_ACCESS  = 2'b01,
    ARB_RELEASE = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic core;
    logic is_dcache;
  } arb_owner_t;

  parameter int ARB_TIMEOUT = 64;
  localparam int ARB_CNT_W  = 7;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    if (v == {ARB_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ARB_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational grant picker.
// Dcache beats icache; within a class the round-robin core goes first.
module arb_select
  import caches_types_pkg::*;
(
  input  logic [1:0] iren,
  input  logic [1:0] dreq,
  input  logic       rr,
  output logic       valid,
  output arb_owner_t owner
);

  // Fixed order: dcache(rr), dcache(!rr), icache(rr), icache(!rr).
  always_comb begin
    valid           = 1'b1;
    owner.core      = 1'b0;
    owner.is_dcache = 1'b0;
    if (dreq[rr]) begin
      owner.core      = rr;
      owner.is_dcache = 1'b1;
    end else if (dreq[~rr]) begin
      owner.core      = ~rr;
      owner.is_dcache = 1'b1;
    end else if (iren[rr]) begin
      owner.core      = rr;
      owner.is_dcache = 1'b0;
    end else if (iren[~rr]) begin
      owner.core      = ~rr;
      owner.is_dcache = 1'b0;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between both cores' icache and dcache.
// One transaction at a time: IDLE picks, ACCESS runs it, RELEASE gives the cache a quiet cycle.
module mem_arbiter
  import caches_types_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        iREN,
  input  logic [NCORES-1:0][31:0]  iaddr,
  output logic [NCORES-1:0][31:0]  iload,
  output logic [NCORES-1:0]        iwait,
  input  logic [NCORES-1:0]        dREN,
  input  logic [NCORES-1:0]        dWEN,
  input  logic [NCORES-1:0][31:0]  daddr,
  input  logic [NCORES-1:0][31:0]  dstore,
  output logic [NCORES-1:0][31:0]  dload,
  output logic [NCORES-1:0]        dwait,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [31:0]              ramaddr,
  output logic [31:0]              ramstore,
  input  logic [31:0]              ramload,
  input  logic                     ram_ready,
  output logic                     timeout,
  output logic [1:0]               owner
);

  localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(TIMEOUT - 1);

  arb_state_t             state_r;
  logic                   rr_r;
  arb_owner_t             owner_r;
  logic [ARB_CNT_W-1:0]   counter_r;
  logic                   timeout_r;

  logic                   sel_valid_s;
  arb_owner_t             sel_owner_s;
  logic [NCORES-1:0]      dreq_s;
  logic                   in_access_s;
  logic                   own_req_s;
  logic                   done_s;
  logic                   abort_s;
  logic                   expire_s;

  assign dreq_s = dREN | dWEN;

  arb_select u_select (
    .iren  (iREN),
    .dreq  (dreq_s),
    .rr    (rr_r),
    .valid (sel_valid_s),
    .owner (sel_owner_s)
  );

  // Owner's live request and the three ways an access can end.
  always_comb begin
    in_access_s = (state_r == ARB_ACCESS);
    if (owner_r.is_dcache) begin
      own_req_s = dreq_s[owner_r.core];
    end else begin
      own_req_s = iREN[owner_r.core];
    end
    done_s   = in_access_s & own_req_s & ram_ready;
    abort_s  = in_access_s & ~own_req_s;
    expire_s = in_access_s & own_req_s & ~ram_ready & (counter_r == CNT_LAST);
  end

  // RAM command mux; a write wins when a dcache raises both enables.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    if (in_access_s && own_req_s) begin
      if (owner_r.is_dcache) begin
        ramaddr  = daddr[owner_r.core];
        ramstore = dstore[owner_r.core];
        ramWEN   = dWEN[owner_r.core];
        ramREN   = dREN[owner_r.core] & ~dWEN[owner_r.core];
      end else begin
        ramaddr  = iaddr[owner_r.core];
        ramREN   = 1'b1;
      end
    end else begin
      ramREN = 1'b0;
    end
  end

  // Completion is combinational so the owner's wait drops in the ram_ready cycle.
  always_comb begin
    iwait = {NCORES{1'b1}};
    dwait = {NCORES{1'b1}};
    iload = '0;
    dload = '0;
    if (done_s) begin
      if (owner_r.is_dcache) begin
        dwait[owner_r.core] = 1'b0;
        dload[owner_r.core] = ramload;
      end else begin
        iwait[owner_r.core] = 1'b0;
        iload[owner_r.core] = ramload;
      end
    end else begin
      iwait = {NCORES{1'b1}};
    end
  end

  // Arbitration FSM, round-robin pointer, access watchdog and timeout pulse.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r   <= ARB_IDLE;
      rr_r      <= 1'b0;
      owner_r   <= '0;
      counter_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (sel_valid_s) begin
            owner_r   <= sel_owner_s;
            counter_r <= '0;
            state_r   <= ARB_ACCESS;
          end else begin
            state_r   <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          if (done_s) begin
            rr_r    <= ~owner_r.core;
            state_r <= ARB_RELEASE;
          end else if (abort_s) begin
            state_r <= ARB_RELEASE;
          end else if (expire_s) begin
            // Pulse is registered, so it shows during the RELEASE cycle.
            rr_r      <= ~owner_r.core;
            timeout_r <= 1'b1;
            state_r   <= ARB_RELEASE;
          end else begin
            counter_r <= sat_inc(counter_r);
          end
        end
        ARB_RELEASE: begin
          state_r <= ARB_IDLE;
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  assign owner   = owner_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand sequences for reset, priority, round-robin, timeout and abort.
module tb_mem_arbiter;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        iREN, dREN, dWEN, iwait, dwait;
  logic [1:0][31:0]  iaddr, iload, daddr, dstore, dload;
  logic              ramREN, ramWEN, ram_ready, timeout;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        owner;

  always #5 CLK = ~CLK;

  mem_arbiter #(.NCORES(2), .TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .timeout(timeout), .owner(owner)
  );

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic        core;
    logic        isd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        core;
    logic        isd;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
    int          delay;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic mid;
    @(negedge CLK);
  endtask

  task automatic push(input logic core, input logic isd, input logic [31:0] data);
    exp_t e;
    e.core = core;
    e.isd  = isd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic got(input int c, input logic isd, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      ntests++;
      nfail++;
      $display("FAIL unexpected_done: core %0d dcache %0b data %h, required no completion", c, isd, data);
    end else begin
      e = sb.pop_front();
      chk("done_who", {30'd0, c[0], isd}, {30'd0, e.core, e.isd});
      chk("done_data", data, e.data);
    end
  endtask

  // No RAM enables, all waits high, all loads zero.
  task automatic quiet(input string tag);
    chk({tag, "_en"}, {30'd0, ramREN, ramWEN}, 32'd0);
    chk({tag, "_wait"}, {28'd0, iwait, dwait}, 32'h0000_000F);
    chk({tag, "_load"}, {31'd0, |{iload, dload}}, 32'd0);
  endtask

  // Completion monitor: any wait that drops is matched against the scoreboard.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      for (int c = 0; c < 2; c++) begin
        if (iwait[c] === 1'b0) got(c, 1'b0, iload[c]);
        if (dwait[c] === 1'b0) got(c, 1'b1, dload[c]);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   c;
    logic exp_ren, exp_wen;
    c       = v.core;
    exp_ren = v.isd ? (v.ren & ~v.wen) : 1'b1;
    exp_wen = v.isd & v.wen;
    ram_ready = 1'b0;
    ramload   = 32'h0;
    if (v.isd) begin
      dREN[c] = v.ren; dWEN[c] = v.wen; daddr[c] = v.addr; dstore[c] = v.store;
    end else begin
      iREN[c] = 1'b1; iaddr[c] = v.addr;
    end
    push(v.core, v.isd, v.rdata);
    mid; quiet("vec_idle");
    tick;
    for (int k = 0; k <= v.delay; k++) begin
      ram_ready = (k == v.delay);
      ramload   = (k == v.delay) ? v.rdata : ~v.rdata;
      mid;
      chk("vec_owner", {30'd0, owner}, {30'd0, v.core, v.isd});
      chk("vec_addr", ramaddr, v.addr);
      chk("vec_en", {30'd0, ramREN, ramWEN}, {30'd0, exp_ren, exp_wen});
      if (exp_wen) chk("vec_store", ramstore, v.store);
      if (k < v.delay) chk("vec_hold", {28'd0, iwait, dwait}, 32'h0000_000F);
      tick;
    end
    ram_ready = 1'b0;
    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
    mid; quiet("vec_release");
    chk("vec_owner_hold", {30'd0, owner}, {30'd0, v.core, v.isd});
    tick;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 2};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'hCAFE_F00D, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0000_0001, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h0000_0002, 3};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 0};

    nRST = 1'b0;
    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = 32'h0; ram_ready = 1'b0;
    repeat (2) tick;
    mid;
    quiet("reset");
    chk("reset_owner", {30'd0, owner}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    nRST = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of an access.
    dREN[0] = 1'b1; daddr[0] = 32'h0000_0500;
    tick; mid;
    chk("mrst_access_ren", {31'd0, ramREN}, 32'd1);
    nRST = 1'b0;
    tick;
    nRST = 1'b1; dREN[0] = 1'b0;
    mid;
    chk("mrst_ren", {31'd0, ramREN}, 32'd0);
    chk("mrst_dwait", {30'd0, dwait}, 32'd3);
    chk("mrst_owner", {30'd0, owner}, 32'd0);
    tick; mid; quiet("mrst_idle");
    tick;

    // Round-robin between two continuously writing dcaches; ram_ready held high.
    dWEN = 2'b11;
    daddr[0] = 32'h0000_1000; daddr[1] = 32'h0000_2000;
    dstore[0] = 32'h1111_1111; dstore[1] = 32'h2222_2222;
    ram_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      ramload = 32'h0000_00F0 + 32'(g);
      push(g[0], 1'b1, ramload);
      mid; quiet("rr_idle");
      tick; mid;
      chk("rr_owner", {30'd0, owner}, {30'd0, g[0], 1'b1});
      chk("rr_en", {30'd0, ramREN, ramWEN}, 32'd1);
      chk("rr_store", ramstore, g[0] ? 32'h2222_2222 : 32'h1111_1111);
      chk("rr_addr", ramaddr, g[0] ? 32'h0000_2000 : 32'h0000_1000);
      tick; mid; quiet("rr_release");
      tick;
    end
    dWEN = 2'b00; ram_ready = 1'b0;

    // Priority: dcache1 beats icache0 with rr=0.
    iREN[0] = 1'b1; iaddr[0] = 32'h0000_0600;
    dREN[1] = 1'b1; daddr[1] = 32'h0000_0700;
    push(1'b1, 1'b1, 32'h0000_AAAA);
    push(1'b0, 1'b0, 32'h0000_BBBB);
    mid; quiet("pri_idle");
    tick; ram_ready = 1'b1; ramload = 32'h0000_AAAA;
    mid;
    chk("pri_owner1", {30'd0, owner}, 32'd3);
    chk("pri_addr1", ramaddr, 32'h0000_0700);
    chk("pri_en1", {30'd0, ramREN, ramWEN}, 32'd2);
    tick; dREN[1] = 1'b0; ram_ready = 1'b0;
    mid; quiet("pri_release");
    tick; mid;
    chk("pri_owner_idle", {30'd0, owner}, 32'd3);
    tick; ram_ready = 1'b1; ramload = 32'h0000_BBBB;
    mid;
    chk("pri_owner2", {30'd0, owner}, 32'd0);
    chk("pri_addr2", ramaddr, 32'h0000_0600);
    tick; iREN[0] = 1'b0; ram_ready = 1'b0;
    mid; quiet("pri_release2");
    tick;

    // Timeout: 64 ACCESS cycles without ram_ready, then pulse and regrant.
    dREN[0] = 1'b1; daddr[0] = 32'h0000_0800;
    tick;
    for (int i = 0; i < 64; i++) begin
      mid;
      chk("to_access", {28'd0, ramREN, timeout, dwait}, 32'h0000_000B);
      tick;
    end
    mid;
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    quiet("to_release");
    tick; mid;
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    tick; ram_ready = 1'b1; ramload = 32'h0000_CCCC;
    push(1'b0, 1'b1, 32'h0000_CCCC);
    mid;
    chk("to_regrant_owner", {30'd0, owner}, 32'd1);
    chk("to_regrant_ren", {31'd0, ramREN}, 32'd1);
    tick; dREN[0] = 1'b0; ram_ready = 1'b0;
    mid; quiet("to_release2");
    tick;

    // Abort: dcache1 drops its request mid-access; rr must stay at core1.
    dREN[1] = 1'b1; daddr[1] = 32'h0000_0900;
    tick; dREN[1] = 1'b0;
    mid;
    chk("ab_owner", {30'd0, owner}, 32'd3);
    chk("ab_ren", {31'd0, ramREN}, 32'd0);
    chk("ab_dwait", {30'd0, dwait}, 32'd3);
    tick; ram_ready = 1'b1; ramload = 32'h0000_5555;
    mid; quiet("ab_release");
    tick; ram_ready = 1'b0;
    dREN = 2'b11; daddr[0] = 32'h0000_0A00; daddr[1] = 32'h0000_0B00;
    push(1'b1, 1'b1, 32'h0000_DDDD);
    mid; quiet("ab_idle");
    tick; ram_ready = 1'b1; ramload = 32'h0000_DDDD;
    mid;
    chk("ab_rr_owner", {30'd0, owner}, 32'd3);
    chk("ab_rr_addr", ramaddr, 32'h0000_0B00);
    tick; dREN = 2'b00; ram_ready = 1'b0;
    mid; quiet("ab_release2");
    tick;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
